// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Word/instruction widths, FSM state encoding and the FIFO entry layout.
package instr_fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int WORD_W  = 64;

    localparam logic [ADDR_W-1:0] INITIAL_PC_DEFAULT = 64'h0;
    localparam int                FETCH_DEPTH        = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] pc);
        return pc & ~64'h7;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory, redirect and instruction-issue signals of the fetch stage.
// master = fetch stage, slave = memory/core side.
interface instr_fetch_if
    import instr_fetch_pkg::*;
    ();

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [WORD_W-1:0]  mem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with two write ports (written in order data0, data1) and one read port.
// push1 is only meaningful together with push0; flush empties the FIFO and beats push/pop.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push0,
    input  fetch_entry_t data0,
    input  logic         push1,
    input  fetch_entry_t data1,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_p1;
    logic          pop_ok;

    assign wr_ptr_p1 = wr_ptr_q + AW'(1);
    assign pop_ok    = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push0) mem_d[wr_ptr_q]  = data0;
            if (push1) mem_d[wr_ptr_p1] = data1;
            wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding 64-bit fetch, split into two instructions buffered in a FIFO.
// Redirect flushes the FIFO and discards any fetch still in flight.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] INITIAL_PC = INITIAL_PC_DEFAULT,
    parameter int                DEPTH      = FETCH_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - 2);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              push0, push1, pop, flush;
    fetch_entry_t      data0, data1, head;
    logic [CW-1:0]     count;
    fetch_entry_t      ent_lo, ent_hi;

    assign ent_lo = '{instr: bus.mem_rdata[31:0],  pc: mem_addr_q};
    assign ent_hi = '{instr: bus.mem_rdata[63:32], pc: mem_addr_q + 64'd4};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push0      = 1'b0;
        push1      = 1'b0;
        data0      = ent_lo;
        data1      = ent_hi;
        flush      = bus.redirect_valid;

        if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc & ~64'h3;

        case (state_q)
            FETCH_IDLE: begin
                if (!bus.redirect_valid && count <= ISSUE_MAX) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = word_addr(fetch_pc_q);
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (bus.redirect_valid) begin
                    if (bus.mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = FETCH_IDLE;
                    end else begin
                        state_d   = FETCH_DROP;
                    end
                end else if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    fetch_pc_d = word_addr(fetch_pc_q) + 64'd8;
                    state_d    = FETCH_IDLE;
                    push0      = 1'b1;
                    // Entry into the upper half skips the low instruction.
                    if (fetch_pc_q[2]) begin
                        data0 = ent_hi;
                    end else begin
                        push1 = 1'b1;
                    end
                end
            end
            FETCH_DROP: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= INITIAL_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign pop = bus.instr_valid && bus.instr_ready;

    instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push0 (push0),
        .data0 (data0),
        .push1 (push1),
        .data1 (data1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;

endmodule
